// File: rtl/nios2_oci_mon_pkg.sv
// nios2_oci_mon_pkg
//   Shared types and helpers for the Nios II OCI trace monitor.
//   - mon_state_t : monitor FSM encoding (RUN/DRAIN/DONE)
//   - sat_inc     : saturating +1 against a caller-supplied ceiling
//   - sat_add     : saturating add against a caller-supplied ceiling
//   - is_pow2     : elaboration-time check for FIFO depth
package nios2_oci_mon_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    DRAIN = 2'b01,
    DONE  = 2'b10
  } mon_state_t;

  // Counters up to 32 bits wide share these helpers; callers cast in and out.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
    return (v >= max) ? max : v + 32'd1;
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] v, input logic [31:0] d,
                                          input logic [31:0] max);
    logic [32:0] s;
    s = {1'b0, v} + {1'b0, d};
    return (s > {1'b0, max}) ? max : s[31:0];
  endfunction

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/nios2_oci_mon_fifo.sv
// nios2_oci_mon_fifo
//   Synchronous FIFO with registered storage; head presented combinationally
//   from the storage array, so a word written into an empty FIFO is visible
//   the cycle after the write.
//   Ports:
//     clk, reset_n      clock, async active-low reset (clears pointers and storage)
//     push, wdata       write request / data
//     pop               read request (ignored when empty)
//     rdata             head word
//     accepted          push taken this cycle (not full, or popping while full)
//     empty             FIFO empty now
//     empty_next        FIFO empty after this cycle's push/pop
module nios2_oci_mon_fifo #(
  parameter int W     = 30,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         accepted,
  output logic         empty,
  output logic         empty_next
);
  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]                 wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [DEPTH-1:0][W-1:0]     mem;
  logic                        full, pop_ok;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok   = pop && !empty;
  // While full, a same-cycle pop frees the head slot that the write reuses.
  assign accepted = push && (!full || pop_ok);

  assign wr_ptr_n   = accepted ? wr_ptr + 1'b1 : wr_ptr;
  assign rd_ptr_n   = pop_ok   ? rd_ptr + 1'b1 : rd_ptr;
  assign empty_next = (wr_ptr_n == rd_ptr_n);
  assign rdata      = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      mem    <= '0;
    end else begin
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      if (accepted) mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/nios2_oci_trace_monitor.sv
// nios2_oci_trace_monitor
//   Debug monitor for the OCI trace capture path. Watches dct_count for
//   advances, buffers dct_buffer into a FIFO, counts captured/dropped/skipped
//   words and issues a pass/fail verdict when the test ends.
//   Optional feature macro: OCI_MON_TIMESTAMP_EN (per-entry capture timestamp).
//   Ports:
//     clk, reset_n                 clock, async active-low reset
//     dct_buffer, dct_count        OCI trace word and free-running commit count
//     test_ending, test_has_ended  end-of-test handshake
//     rd_valid/rd_ready/rd_data/rd_ts  FIFO drain port
//     capt_cnt, drop_cnt, gap_cnt  saturating statistics
//     mon_state, done, pass        FSM state and sticky verdict
module nios2_oci_trace_monitor
  import nios2_oci_mon_pkg::*;
#(
  parameter int DATA_W  = 30,
  parameter int COUNT_W = 4,
  parameter int DEPTH   = 16,
  parameter int CNT_W   = 16,
  parameter int TS_W    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] dct_buffer,
  input  logic [COUNT_W-1:0] dct_count,
  input  logic              test_ending,
  input  logic              test_has_ended,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic [TS_W-1:0]   rd_ts,
  output logic [CNT_W-1:0]  capt_cnt,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [CNT_W-1:0]  gap_cnt,
  output logic [1:0]        mon_state,
  output logic              done,
  output logic              pass
);

  generate
    if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
      $error("nios2_oci_trace_monitor: DEPTH must be a power of two >= 2");
    end
    if (CNT_W > 32) begin : g_bad_cntw
      $error("nios2_oci_trace_monitor: CNT_W must be <= 32");
    end
  endgenerate

  localparam logic [31:0] CNT_MAX = 32'({CNT_W{1'b1}});

  mon_state_t           state_q, state_d;
  logic [COUNT_W-1:0]   prev_cnt, delta;
  logic                 primed, capture, pop, accepted, empty, empty_next;
  logic [CNT_W-1:0]     capt_d, drop_d, gap_d;

  // ---------------- delta / capture ----------------
  // Modular subtraction makes F->0 a delta of 1.
  assign delta   = dct_count - prev_cnt;
  assign capture = primed && (state_q == RUN) && !test_ending && (delta != '0);
  assign pop     = rd_valid && rd_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_cnt <= '0;
      primed   <= 1'b0;
    end else begin
      prev_cnt <= dct_count;
      primed   <= 1'b1;
    end
  end

  // ---------------- FIFO ----------------
`ifdef OCI_MON_TIMESTAMP_EN
  logic [TS_W-1:0]        ts;
  logic [TS_W+DATA_W-1:0] head;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ts <= '0;
    else          ts <= ts + 1'b1;
  end

  nios2_oci_mon_fifo #(.W(TS_W + DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (capture),
    .wdata      ({ts, dct_buffer}),
    .pop        (pop),
    .rdata      (head),
    .accepted   (accepted),
    .empty      (empty),
    .empty_next (empty_next)
  );

  assign rd_data = head[DATA_W-1:0];
  assign rd_ts   = head[TS_W+DATA_W-1:DATA_W];
`else
  nios2_oci_mon_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (capture),
    .wdata      (dct_buffer),
    .pop        (pop),
    .rdata      (rd_data),
    .accepted   (accepted),
    .empty      (empty),
    .empty_next (empty_next)
  );

  assign rd_ts = '0;
`endif

  assign rd_valid = !empty;

  // ---------------- counters ----------------
  always_comb begin
    capt_d = capt_cnt;
    drop_d = drop_cnt;
    gap_d  = gap_cnt;
    if (capture) begin
      gap_d = CNT_W'(sat_add(32'(gap_cnt), 32'(delta - 1'b1), CNT_MAX));
      if (accepted) capt_d = CNT_W'(sat_inc(32'(capt_cnt), CNT_MAX));
      else          drop_d = CNT_W'(sat_inc(32'(drop_cnt), CNT_MAX));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      capt_cnt <= '0;
      drop_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      capt_cnt <= capt_d;
      drop_cnt <= drop_d;
      gap_cnt  <= gap_d;
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= RUN;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (test_has_ended) state_d = DONE;
               else if (test_ending) state_d = DRAIN;
      DRAIN:   if (test_has_ended) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = RUN;
    endcase
  end

  assign mon_state = state_q;

  // Verdict is latched once on the edge entering DONE and then frozen; it
  // reflects occupancy and statistics as they stand after that edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done <= 1'b0;
      pass <= 1'b0;
    end else if (state_q != DONE && state_d == DONE) begin
      done <= 1'b1;
      pass <= empty_next && (drop_d == '0) && (gap_d == '0);
    end
  end

endmodule

// File: tb/tb_nios2_oci_trace_monitor.sv
module tb_nios2_oci_trace_monitor;
  localparam int DATA_W = 30, COUNT_W = 4, DEPTH = 16, CNT_W = 16, TS_W = 16;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [DATA_W-1:0] dct_buffer = '0;
  logic [COUNT_W-1:0] dct_count = '0;
  logic              test_ending = 1'b0, test_has_ended = 1'b0;
  logic              rd_valid, rd_ready = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic [TS_W-1:0]   rd_ts;
  logic [CNT_W-1:0]  capt_cnt, drop_cnt, gap_cnt;
  logic [1:0]        mon_state;
  logic              done, pass;

  int n_cmp = 0;
  int n_err = 0;

  nios2_oci_trace_monitor #(
    .DATA_W(DATA_W), .COUNT_W(COUNT_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .TS_W(TS_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .dct_buffer(dct_buffer), .dct_count(dct_count),
    .test_ending(test_ending), .test_has_ended(test_has_ended),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_ts(rd_ts),
    .capt_cnt(capt_cnt), .drop_cnt(drop_cnt), .gap_cnt(gap_cnt),
    .mon_state(mon_state), .done(done), .pass(pass)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Step dct_count/dct_buffer for one clock.
  task automatic step(input logic [COUNT_W-1:0] c, input logic [DATA_W-1:0] b);
    dct_count  = c;
    dct_buffer = b;
    tick();
  endtask

  // Reset, then one priming cycle at count c.
  task automatic restart(input logic [COUNT_W-1:0] c);
    reset_n = 1'b0;
    test_ending = 1'b0; test_has_ended = 1'b0; rd_ready = 1'b0;
    dct_count = c; dct_buffer = '0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    // ---- reset state ----
    #2;
    chk("rst_valid", 64'(rd_valid), 64'd0);
    chk("rst_capt",  64'(capt_cnt), 64'd0);
    chk("rst_state", 64'(mon_state), 64'd0);
    chk("rst_done",  64'({done, pass}), 64'd0);

    // ---- counting and drain ----
    restart(4'd0);
    rd_ready = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      step(COUNT_W'(n), DATA_W'(32'h100 + n));
      chk($sformatf("cnt_head%0d", n), 64'({rd_valid, rd_data}), 64'({1'b1, DATA_W'(32'h100 + n)}));
`ifdef OCI_MON_TIMESTAMP_EN
      chk($sformatf("cnt_ts%0d", n), 64'(rd_ts), 64'(n));
`else
      chk($sformatf("cnt_ts%0d", n), 64'(rd_ts), 64'd0);
`endif
    end
    step(4'd5, 30'h105);
    chk("cnt_empty", 64'(rd_valid), 64'd0);
    chk("cnt_capt", 64'(capt_cnt), 64'd5);
    test_has_ended = 1'b1;
    tick();
    chk("cnt_verdict", 64'({mon_state, done, pass}), 64'({2'b10, 1'b1, 1'b1}));

    // ---- wrap ----
    restart(4'hE);
    step(4'hF, 30'h20);
    step(4'h0, 30'h21);
    step(4'h1, 30'h22);
    chk("wrap_capt", 64'(capt_cnt), 64'd3);
    chk("wrap_gap", 64'(gap_cnt), 64'd0);
    chk("wrap_head", 64'(rd_data), 64'h20);

    // ---- gap ----
    restart(4'd3);
    rd_ready = 1'b1;
    step(4'd7, 30'h77);
    chk("gap_capt", 64'(capt_cnt), 64'd1);
    chk("gap_gap", 64'(gap_cnt), 64'd3);
    step(4'd7, 30'h77);
    chk("gap_empty", 64'(rd_valid), 64'd0);
    test_has_ended = 1'b1;
    tick();
    chk("gap_verdict", 64'({done, pass}), 64'({1'b1, 1'b0}));

    // ---- overflow then full with pop ----
    restart(4'd0);
    for (int n = 1; n <= 20; n++) step(COUNT_W'(n), DATA_W'(n));
    chk("ovf_capt", 64'(capt_cnt), 64'd16);
    chk("ovf_drop", 64'(drop_cnt), 64'd4);
    chk("ovf_head", 64'({rd_valid, rd_data}), 64'({1'b1, 30'd1}));
    rd_ready = 1'b1;
    step(4'd5, 30'h55);                // 21 mod 16 = 5: one more increment
    chk("fullpop_capt", 64'(capt_cnt), 64'd17);
    chk("fullpop_drop", 64'(drop_cnt), 64'd4);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("fullpop_rd%0d", i), 64'({rd_valid, rd_data}),
          64'({1'b1, (i < 15) ? DATA_W'(i + 2) : 30'h55}));
      tick();
    end
    chk("fullpop_empty", 64'(rd_valid), 64'd0);
    test_has_ended = 1'b1;
    tick();
    chk("ovf_verdict", 64'({done, pass}), 64'({1'b1, 1'b0}));

    // ---- ending mid-stream, then early end with 2 unread ----
    restart(4'd0);
    step(4'd1, 30'h301);
    step(4'd2, 30'h302);
    test_ending = 1'b1;
    step(4'd3, 30'h303);
    chk("end_state", 64'(mon_state), 64'd1);
    step(4'd4, 30'h304);
    chk("end_capt", 64'(capt_cnt), 64'd2);
    test_has_ended = 1'b1;
    tick();
    chk("early_verdict", 64'({mon_state, done, pass}), 64'({2'b10, 1'b1, 1'b0}));
    rd_ready = 1'b1;
    chk("early_head", 64'({rd_valid, rd_data}), 64'({1'b1, 30'h301}));
    tick();
    chk("early_head2", 64'({rd_valid, rd_data}), 64'({1'b1, 30'h302}));
    tick();
    chk("early_frozen", 64'({rd_valid, done, pass}), 64'({1'b0, 1'b1, 1'b0}));

    // ---- ending and ended together ----
    restart(4'd0);
    test_ending = 1'b1; test_has_ended = 1'b1;
    tick();
    chk("both_verdict", 64'({mon_state, done, pass}), 64'({2'b10, 1'b1, 1'b1}));

    // ---- async reset mid-run ----
    restart(4'd0);
    step(4'd1, 30'h1);
    step(4'd2, 30'h2);
    step(4'd3, 30'h3);
    chk("pre_rst_capt", 64'(capt_cnt), 64'd3);
    #3 reset_n = 1'b0;
    #1;
    chk("arst_valid", 64'({rd_valid, rd_data}), 64'd0);
    chk("arst_cnts", 64'({capt_cnt, drop_cnt, gap_cnt}), 64'd0);
    chk("arst_state", 64'({mon_state, done, pass}), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
